// File: rtl/enigma_pipe.sv
// Eight-stage pipelined Enigma (rotors III/II/I, reflector UKW-B, rings at 'A').
// Define ENIGMA_PLUGBOARD_EN to add the writable plugboard and its ports.
module enigma_pipe #(
    parameter int unsigned R1_INIT_VALUE = 1,
    parameter int unsigned R2_INIT_VALUE = 1,
    parameter int unsigned R3_INIT_VALUE = 1,
    parameter int unsigned R1_NOTCH      = 22,
    parameter int unsigned R2_NOTCH      = 5
) (
    input  logic       clk_i,
    input  logic       rst_i,
`ifdef ENIGMA_PLUGBOARD_EN
    input  logic       plug_wr_i,
    input  logic [6:0] plug_a_i,
    input  logic [6:0] plug_b_i,
`endif
    input  logic       pos_load_i,
    input  logic [6:0] pos_r1_i,
    input  logic [6:0] pos_r2_i,
    input  logic [6:0] pos_r3_i,
    output logic [6:0] pos_r1_o,
    output logic [6:0] pos_r2_o,
    output logic [6:0] pos_r3_o,
    input  logic [6:0] in_symb_i,
    input  logic       in_symb_val_i,
    output logic       in_symb_rdy_o,
    output logic [6:0] out_symb_o,
    output logic       out_symb_val_o,
    input  logic       out_symb_rdy_i,
    output logic       out_err_o
);

    localparam int unsigned SYM_W  = 7;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned N_LET  = 26;
    localparam int unsigned TBL_W  = 8 * N_LET;
    localparam int unsigned N_STG  = 7;

    // Wiring strings: leftmost character is the image of 'A'.
    localparam logic [TBL_W-1:0] ROT_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    localparam logic [TBL_W-1:0] ROT_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    localparam logic [TBL_W-1:0] ROT_III = "BDFHJLCPRTXVZNYEIWGAKMQOUS";
    localparam logic [TBL_W-1:0] UKW_B   = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    typedef struct packed {
        logic             vld;
        logic             err;
        logic [IDX_W-1:0] sym;
        logic [IDX_W-1:0] o1;
        logic [IDX_W-1:0] o2;
        logic [IDX_W-1:0] o3;
    } stage_t;

    function automatic logic is_letter(input logic [SYM_W-1:0] p);
        return (p >= SYM_W'(1)) && (p <= SYM_W'(N_LET));
    endfunction

    function automatic logic [SYM_W-1:0] inc_pos(input logic [SYM_W-1:0] p);
        return (p == SYM_W'(N_LET)) ? SYM_W'(1) : SYM_W'(p + SYM_W'(1));
    endfunction

    function automatic logic [IDX_W-1:0] pos_to_off(input logic [SYM_W-1:0] p);
        return IDX_W'(p - SYM_W'(1));
    endfunction

    function automatic logic [IDX_W-1:0] add_mod(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b);
        logic [IDX_W:0] s;
        s = (IDX_W+1)'(a) + (IDX_W+1)'(b);
        if (s >= (IDX_W+1)'(N_LET)) s = s - (IDX_W+1)'(N_LET);
        return IDX_W'(s);
    endfunction

    // Subtraction stays unsigned by adding 26 before removing the offset.
    function automatic logic [IDX_W-1:0] sub_mod(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b);
        logic [IDX_W:0] s;
        s = (IDX_W+1)'(a) + (IDX_W+1)'(N_LET) - (IDX_W+1)'(b);
        if (s >= (IDX_W+1)'(N_LET)) s = s - (IDX_W+1)'(N_LET);
        return IDX_W'(s);
    endfunction

    function automatic logic [IDX_W-1:0] map_fwd(input logic [TBL_W-1:0] tbl,
                                                 input logic [IDX_W-1:0] c);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N_LET); i++) begin
            if (c == IDX_W'(i)) r = IDX_W'(tbl[8*(25-i) +: 8] - 8'd65);
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] map_inv(input logic [TBL_W-1:0] tbl,
                                                 input logic [IDX_W-1:0] c);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N_LET); i++) begin
            if (IDX_W'(tbl[8*(25-i) +: 8] - 8'd65) == c) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] rotor_fwd(input logic [TBL_W-1:0] tbl,
                                                   input logic [IDX_W-1:0] c,
                                                   input logic [IDX_W-1:0] o);
        return sub_mod(map_fwd(tbl, add_mod(c, o)), o);
    endfunction

    function automatic logic [IDX_W-1:0] rotor_bwd(input logic [TBL_W-1:0] tbl,
                                                   input logic [IDX_W-1:0] c,
                                                   input logic [IDX_W-1:0] o);
        return sub_mod(map_inv(tbl, add_mod(c, o)), o);
    endfunction

    logic             stall;
    logic             accept;
    logic             in_range;
    logic             step_r2;
    logic             step_r3;
    logic [SYM_W-1:0] r1_nxt;
    logic [SYM_W-1:0] r2_nxt;
    logic [SYM_W-1:0] r3_nxt;
    logic [IDX_W-1:0] raw_in_idx;
    logic [IDX_W-1:0] raw_out_idx;
    logic [IDX_W-1:0] plug_in_idx;
    logic [IDX_W-1:0] plug_out_idx;
    stage_t           st_q [N_STG];
    stage_t           st_d [N_STG];

    assign stall         = out_symb_val_o && !out_symb_rdy_i;
    assign in_symb_rdy_o = !rst_i && !pos_load_i && !stall;
    assign accept        = in_symb_val_i && in_symb_rdy_o;
    assign in_range      = is_letter(in_symb_i);
    assign raw_in_idx    = IDX_W'(in_symb_i - SYM_W'(1));
    assign raw_out_idx   = rotor_bwd(ROT_III, st_q[6].sym, st_q[6].o1);

`ifdef ENIGMA_PLUGBOARD_EN
    localparam int unsigned PLUG_W = IDX_W * N_LET;

    logic [PLUG_W-1:0] plug_tbl;
    logic [IDX_W-1:0]  plug_a_idx;
    logic [IDX_W-1:0]  plug_b_idx;

    function automatic logic [IDX_W-1:0] plug_lookup(input logic [PLUG_W-1:0] tbl,
                                                     input logic [IDX_W-1:0]  c);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N_LET); i++) begin
            if (c == IDX_W'(i)) r = tbl[IDX_W*i +: IDX_W];
        end
        return r;
    endfunction

    assign plug_a_idx   = IDX_W'(plug_a_i - SYM_W'(1));
    assign plug_b_idx   = IDX_W'(plug_b_i - SYM_W'(1));
    assign plug_in_idx  = plug_lookup(plug_tbl, raw_in_idx);
    assign plug_out_idx = plug_lookup(plug_tbl, raw_out_idx);

    // Pair swap table; writes naming a non-letter are dropped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(N_LET); i++) plug_tbl[IDX_W*i +: IDX_W] <= IDX_W'(i);
        end else if (plug_wr_i && is_letter(plug_a_i) && is_letter(plug_b_i)) begin
            plug_tbl[IDX_W*int'(plug_a_idx) +: IDX_W] <= plug_b_idx;
            plug_tbl[IDX_W*int'(plug_b_idx) +: IDX_W] <= plug_a_idx;
        end
    end
`else
    assign plug_in_idx  = raw_in_idx;
    assign plug_out_idx = raw_out_idx;
`endif

    // Rotor stepping, decided from the pre-step positions (gives the double step).
    assign step_r2 = (pos_r1_o == SYM_W'(R1_NOTCH)) || (pos_r2_o == SYM_W'(R2_NOTCH));
    assign step_r3 = (pos_r2_o == SYM_W'(R2_NOTCH));

    always_comb begin
        r1_nxt = pos_r1_o;
        r2_nxt = pos_r2_o;
        r3_nxt = pos_r3_o;
        if (accept && in_range) begin
            r1_nxt = inc_pos(pos_r1_o);
            if (step_r2) r2_nxt = inc_pos(pos_r2_o);
            if (step_r3) r3_nxt = inc_pos(pos_r3_o);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_r1_o <= SYM_W'(R1_INIT_VALUE);
            pos_r2_o <= SYM_W'(R2_INIT_VALUE);
            pos_r3_o <= SYM_W'(R3_INIT_VALUE);
        end else if (pos_load_i) begin
            pos_r1_o <= is_letter(pos_r1_i) ? pos_r1_i : SYM_W'(1);
            pos_r2_o <= is_letter(pos_r2_i) ? pos_r2_i : SYM_W'(1);
            pos_r3_o <= is_letter(pos_r3_i) ? pos_r3_i : SYM_W'(1);
        end else begin
            pos_r1_o <= r1_nxt;
            pos_r2_o <= r2_nxt;
            pos_r3_o <= r3_nxt;
        end
    end

    // Stage datapath; each symbol carries its own rotor offsets.
    always_comb begin
        for (int k = 1; k < int'(N_STG); k++) st_d[k] = st_q[k-1];
        st_d[0].vld = accept;
        st_d[0].err = !in_range;
        st_d[0].sym = in_range ? plug_in_idx : '0;
        st_d[0].o1  = pos_to_off(r1_nxt);
        st_d[0].o2  = pos_to_off(r2_nxt);
        st_d[0].o3  = pos_to_off(r3_nxt);
        st_d[1].sym = rotor_fwd(ROT_III, st_q[0].sym, st_q[0].o1);
        st_d[2].sym = rotor_fwd(ROT_II,  st_q[1].sym, st_q[1].o2);
        st_d[3].sym = rotor_fwd(ROT_I,   st_q[2].sym, st_q[2].o3);
        st_d[4].sym = map_fwd(UKW_B, st_q[3].sym);
        st_d[5].sym = rotor_bwd(ROT_I,   st_q[4].sym, st_q[4].o3);
        st_d[6].sym = rotor_bwd(ROT_II,  st_q[5].sym, st_q[5].o2);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(N_STG); k++) st_q[k] <= '0;
            out_symb_val_o <= 1'b0;
            out_symb_o     <= '0;
            out_err_o      <= 1'b0;
        end else if (!stall) begin
            for (int k = 0; k < int'(N_STG); k++) st_q[k] <= st_d[k];
            out_symb_val_o <= st_q[6].vld;
            out_err_o      <= st_q[6].vld && st_q[6].err;
            out_symb_o     <= (st_q[6].vld && !st_q[6].err) ?
                              SYM_W'(SYM_W'(plug_out_idx) + SYM_W'(1)) : '0;
        end
    end

endmodule

// File: tb/tb_enigma_pipe.sv
// Scoreboard bench for enigma_pipe: directed letters with hand-computed ciphertext.
module tb_enigma_pipe;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       pos_load_i;
    logic [6:0] pos_r1_i, pos_r2_i, pos_r3_i;
    logic [6:0] pos_r1_o, pos_r2_o, pos_r3_o;
    logic [6:0] in_symb_i;
    logic       in_symb_val_i;
    logic       in_symb_rdy_o;
    logic [6:0] out_symb_o;
    logic       out_symb_val_o;
    logic       out_symb_rdy_i;
    logic       out_err_o;

    typedef struct {
        logic [6:0] sym;
        logic       err;
        int         stamp;
        bit         lat;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    enigma_pipe dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pos_load_i     (pos_load_i),
        .pos_r1_i       (pos_r1_i),
        .pos_r2_i       (pos_r2_i),
        .pos_r3_i       (pos_r3_i),
        .pos_r1_o       (pos_r1_o),
        .pos_r2_o       (pos_r2_o),
        .pos_r3_o       (pos_r3_o),
        .in_symb_i      (in_symb_i),
        .in_symb_val_i  (in_symb_val_i),
        .in_symb_rdy_o  (in_symb_rdy_o),
        .out_symb_o     (out_symb_o),
        .out_symb_val_o (out_symb_val_o),
        .out_symb_rdy_i (out_symb_rdy_i),
        .out_err_o      (out_err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    endfunction

    // Monitor: every output handshake pops one expectation.
    always @(negedge clk_i) begin
        exp_t e;
        if (out_symb_val_o && out_symb_rdy_i) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL spurious_out: got symbol %0d err %0d, expected none", out_symb_o, out_err_o);
            end else begin
                e = sb.pop_front();
                chk("out_symb", int'(out_symb_o), int'(e.sym));
                chk("out_err", int'(out_err_o), int'(e.err));
                if (e.lat) chk("latency", cyc - e.stamp, 7);
            end
        end
    end

    task automatic send(input logic [6:0] s, input logic [6:0] es, input logic ee,
                        input bit push, input bit lat);
        int n;
        n = 0;
        in_symb_i     = s;
        in_symb_val_i = 1'b1;
        @(negedge clk_i);
        while (!in_symb_rdy_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!in_symb_rdy_o) begin
            chk("send_timeout", int'(in_symb_rdy_o), 1);
            in_symb_val_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1;
        in_symb_val_i = 1'b0;
        if (push) sb.push_back('{es, ee, cyc, lat});
    endtask

    task automatic check_pos(input string tag, input int r3, input int r2, input int r1);
        chk({tag, "_r3"}, int'(pos_r3_o), r3);
        chk({tag, "_r2"}, int'(pos_r2_o), r2);
        chk({tag, "_r1"}, int'(pos_r1_o), r1);
    endtask

    task automatic load_pos(input logic [6:0] r3, input logic [6:0] r2, input logic [6:0] r1);
        pos_r3_i   = r3;
        pos_r2_i   = r2;
        pos_r1_i   = r1;
        pos_load_i = 1'b1;
        @(negedge clk_i);
        chk("rdy_during_load", int'(in_symb_rdy_o), 0);
        @(posedge clk_i);
        #1;
        pos_load_i = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk_i);
            n++;
        end
        repeat (2) @(posedge clk_i);
        #1;
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst_i          = 1'b1;
        pos_load_i     = 1'b0;
        pos_r1_i       = '0;
        pos_r2_i       = '0;
        pos_r3_i       = '0;
        in_symb_i      = '0;
        in_symb_val_i  = 1'b0;
        out_symb_rdy_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_in_rdy", int'(in_symb_rdy_o), 0);
        chk("rst_out_val", int'(out_symb_val_o), 0);
        chk("rst_out_symb", int'(out_symb_o), 0);
        chk("rst_out_err", int'(out_err_o), 0);
        check_pos("rst_pos", 1, 1, 1);
        rst_i = 1'b0;

        // AAAAA from AAA gives BDZGO
        send(7'd1, 7'd2,  1'b0, 1'b1, 1'b1);
        send(7'd1, 7'd4,  1'b0, 1'b1, 1'b0);
        send(7'd1, 7'd26, 1'b0, 1'b1, 1'b0);
        send(7'd1, 7'd7,  1'b0, 1'b1, 1'b0);
        send(7'd1, 7'd15, 1'b0, 1'b1, 1'b0);
        check_pos("after_5", 1, 1, 6);
        drain("drain_bdzgo");

        // Involution: BDZGO from AAA decodes to AAAAA
        pulse_reset();
        send(7'd2,  7'd1, 1'b0, 1'b1, 1'b0);
        send(7'd4,  7'd1, 1'b0, 1'b1, 1'b0);
        send(7'd26, 7'd1, 1'b0, 1'b1, 1'b0);
        send(7'd7,  7'd1, 1'b0, 1'b1, 1'b0);
        send(7'd15, 7'd1, 1'b0, 1'b1, 1'b0);
        drain("drain_inv");

        // Double step from A D U
        load_pos(7'd1, 7'd4, 7'd21);
        check_pos("load", 1, 4, 21);
        send(7'd1, 7'd3, 1'b0, 1'b1, 1'b0);
        check_pos("dstep1", 1, 4, 22);
        send(7'd1, 7'd2, 1'b0, 1'b1, 1'b0);
        check_pos("dstep2", 1, 5, 23);
        send(7'd1, 7'd21, 1'b0, 1'b1, 1'b0);
        check_pos("dstep3", 2, 6, 24);
        drain("drain_dstep");

        // Back-pressure: stall on the second output for 5 cycles
        pulse_reset();
        send(7'd1, 7'd2,  1'b0, 1'b1, 1'b0);
        send(7'd1, 7'd4,  1'b0, 1'b1, 1'b0);
        send(7'd1, 7'd26, 1'b0, 1'b1, 1'b0);
        send(7'd1, 7'd7,  1'b0, 1'b1, 1'b0);
        send(7'd1, 7'd15, 1'b0, 1'b1, 1'b0);
        n = 0;
        @(negedge clk_i);
        while (!out_symb_val_o && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        chk("stall_out_seen", int'(out_symb_val_o), 1);
        @(posedge clk_i);
        #1;
        out_symb_rdy_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("stall_in_rdy", int'(in_symb_rdy_o), 0);
            chk("stall_out_hold", int'(out_symb_o), 4);
            chk("stall_out_val", int'(out_symb_val_o), 1);
        end
        @(posedge clk_i);
        #1;
        out_symb_rdy_i = 1'b1;
        drain("drain_stall");

        // Out-of-range letters pass through as errors without stepping
        check_pos("pre_err", 1, 1, 6);
        send(7'd0, 7'd0, 1'b1, 1'b1, 1'b0);
        check_pos("err0", 1, 1, 6);
        send(7'd27, 7'd0, 1'b1, 1'b1, 1'b0);
        check_pos("err27", 1, 1, 6);
        send(7'd1, 7'd23, 1'b0, 1'b1, 1'b0);
        check_pos("after_err", 1, 1, 7);
        drain("drain_err");

        // Load sanitising and reset priority over load
        load_pos(7'd0, 7'd27, 7'd5);
        check_pos("load_clamp", 1, 1, 5);
        pos_r3_i   = 7'd3;
        pos_r2_i   = 7'd3;
        pos_r1_i   = 7'd3;
        pos_load_i = 1'b1;
        rst_i      = 1'b1;
        @(posedge clk_i);
        #1;
        pos_load_i = 1'b0;
        rst_i      = 1'b0;
        check_pos("rst_over_load", 1, 1, 1);

        // Reset with four symbols in flight discards them
        load_pos(7'd5, 7'd9, 7'd13);
        send(7'd3, 7'd0, 1'b0, 1'b0, 1'b0);
        send(7'd8, 7'd0, 1'b0, 1'b0, 1'b0);
        send(7'd5, 7'd0, 1'b0, 1'b0, 1'b0);
        send(7'd20, 7'd0, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        check_pos("flush_pos", 1, 1, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            chk("flush_no_valid", int'(out_symb_val_o), 0);
        end
        @(posedge clk_i);
        #1;
        send(7'd1, 7'd2, 1'b0, 1'b1, 1'b1);
        drain("drain_final");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
